vga_scan_engine: RTL and testbench

//  Parametrised VGA timing and pixel-fetch engine; successor to the fixed 640x480 controller.

---
 rtl/vga_scan_engine.sv | 169 ++++++++++++++++
 tb/tb_vga_scan_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// Parametrised VGA timing generator and framebuffer pixel-fetch engine.
// Latency: read address/strobe are combinational from the counters; pins follow RD_LAT+1 cycles later.
// Backpressure: none from the RAM; i_en=0 freezes the scan position and injects blank entries.
//
// Ports:
//   i_clk, i_reset             pixel clock, synchronous active-high reset
//   i_en                       1 = scan advances, 0 = counters hold
//   o_rd_en, o_rd_addr_x/y     framebuffer read strobe and address (stage 0)
//   i_rd_data                  {r,g,b} returned RD_LAT cycles after o_rd_en
//   o_hsync, o_vsync, o_valid  sync and visibility aligned to the output pixel
//   o_vga_r/g/b                registered pixel colour, zero outside the visible area
//   o_frame_start/line_start   pulses with output pixel (0,0) / x=0 of each active line
module vga_scan_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int RD_LAT      = 1,
  parameter int SCALE_SHIFT = 0,
  parameter int ADDR_W      = 10,
  parameter int COLOR_W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  output logic                   o_rd_en,
  output logic [ADDR_W-1:0]      o_rd_addr_x,
  output logic [ADDR_W-1:0]      o_rd_addr_y,
  input  logic [3*COLOR_W-1:0]   i_rd_data,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_valid,
  output logic [COLOR_W-1:0]     o_vga_r,
  output logic [COLOR_W-1:0]     o_vga_g,
  output logic [COLOR_W-1:0]     o_vga_b,
  output logic                   o_frame_start,
  output logic                   o_line_start
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam int CW        = $clog2(MAX_TOTAL);

  localparam logic [CW-1:0] ONE_C    = CW'(1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  // Per-pixel tag carried alongside the RAM read; hs/vs mean "sync asserted".
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic h0;
    logic v0;
  } tag_t;

  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_en) begin
      if (r_h_cnt == H_LAST_C) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST_C) ? '0 : r_v_cnt + ONE_C;
      end else begin
        r_h_cnt <= r_h_cnt + ONE_C;
      end
    end
  end

  logic w_h_act;
  logic w_v_act;
  logic w_hs_raw;
  logic w_vs_raw;
  tag_t w_tag0;
  tag_t w_tag_out;

  assign w_h_act  = (r_h_cnt < H_ACT_C);
  assign w_v_act  = (r_v_cnt < V_ACT_C);
  assign w_hs_raw = (r_h_cnt >= HS_BEG_C) && (r_h_cnt <= HS_END_C);
  assign w_vs_raw = (r_v_cnt >= VS_BEG_C) && (r_v_cnt <= VS_END_C);

  assign o_rd_en     = i_en & w_h_act & w_v_act;
  assign o_rd_addr_x = ADDR_W'(r_h_cnt >> SCALE_SHIFT);
  assign o_rd_addr_y = ADDR_W'(r_v_cnt >> SCALE_SHIFT);

  // A paused cycle enters the delay line as a blank entry so the pins blank
  // for exactly as long as the pause, RD_LAT+1 cycles later.
  always_comb begin
    w_tag0     = '0;
    w_tag0.act = o_rd_en;
    w_tag0.hs  = i_en & w_hs_raw;
    w_tag0.vs  = i_en & w_vs_raw;
    w_tag0.h0  = (r_h_cnt == '0);
    w_tag0.v0  = (r_v_cnt == '0);
  end

  // RD_LAT tag stages line the tag up with i_rd_data; the output register
  // below is the final stage.
  generate
    if (RD_LAT == 0) begin : g_nolat
      assign w_tag_out = w_tag0;
    end else begin : g_lat
      tag_t r_pipe [RD_LAT];
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_tag0;
          for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_tag_out = r_pipe[RD_LAT-1];
    end
  endgenerate

  logic                 r_valid;
  logic [3*COLOR_W-1:0] r_rgb;
  logic                 r_hsync;
  logic                 r_vsync;
  logic                 r_frame_start;
  logic                 r_line_start;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid       <= 1'b0;
      r_rgb         <= '0;
      r_hsync       <= ~HS_ACT;
      r_vsync       <= ~VS_ACT;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_valid       <= w_tag_out.act;
      r_rgb         <= w_tag_out.act ? i_rd_data : '0;
      r_hsync       <= w_tag_out.hs ? HS_ACT : ~HS_ACT;
      r_vsync       <= w_tag_out.vs ? VS_ACT : ~VS_ACT;
      r_frame_start <= w_tag_out.act & w_tag_out.h0 & w_tag_out.v0;
      r_line_start  <= w_tag_out.act & w_tag_out.h0;
    end
  end

  assign o_valid       = r_valid;
  assign o_vga_r       = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign o_vga_g       = r_rgb[2*COLOR_W-1:COLOR_W];
  assign o_vga_b       = r_rgb[COLOR_W-1:0];
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_frame_start = r_frame_start;
  assign o_line_start  = r_line_start;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on the small 14x7 timing, several configurations side by side:
// instance 0 RD_LAT=2 native, instance 1 RD_LAT=2 doubled, instances 2..6 RD_LAT=0..4 with active-high syncs.
// All instances share clock, reset and enable; each has its own latency-matched RAM model.
module tb_vga_scan_engine;

  localparam int N = 7;

  function automatic int lat_of(input int g);
    return (g < 2) ? 2 : g - 2;
  endfunction
  function automatic int ss_of(input int g);
    return (g == 1) ? 1 : 0;
  endfunction
  function automatic int pol_of(input int g);
    return (g >= 2) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst_i;
  logic en_i;
  logic [23:0] junk;
  logic [7:0] kr, kg, kb;

  logic        rd_en_a [N];
  logic [9:0]  ax_a    [N];
  logic [9:0]  ay_a    [N];
  logic        val_a   [N];
  logic        hs_a    [N];
  logic        vs_a    [N];
  logic        fs_a    [N];
  logic        ls_a    [N];
  logic [23:0] rgb_a   [N];

  int n_cmp = 0;
  int n_err = 0;

  // Framebuffer content: pixel (x,y) holds {x^kr, y^kg, x^y^kb}.
  function automatic logic [23:0] pix(input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb ^ kr, yb ^ kg, (xb ^ yb) ^ kb};
  endfunction

  initial forever #5 clk = ~clk;

  always @(posedge clk) junk <= 24'($urandom);

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = lat_of(g);
    logic [23:0] rdat;
    logic [7:0]  vr, vg, vb;

    vga_scan_engine #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(pol_of(g)), .VS_POL(pol_of(g)), .RD_LAT(L),
      .SCALE_SHIFT(ss_of(g)), .ADDR_W(10), .COLOR_W(8)
    ) u_dut (
      .i_clk(clk), .i_reset(rst_i), .i_en(en_i),
      .o_rd_en(rd_en_a[g]), .o_rd_addr_x(ax_a[g]), .o_rd_addr_y(ay_a[g]),
      .i_rd_data(rdat),
      .o_hsync(hs_a[g]), .o_vsync(vs_a[g]), .o_valid(val_a[g]),
      .o_vga_r(vr), .o_vga_g(vg), .o_vga_b(vb),
      .o_frame_start(fs_a[g]), .o_line_start(ls_a[g])
    );
    assign rgb_a[g] = {vr, vg, vb};

    // RAM model: data for an address appears L cycles after the read; junk otherwise.
    if (L == 0) begin : g_ram0
      assign rdat = rd_en_a[g] ? pix(int'(ax_a[g]), int'(ay_a[g])) : junk;
    end else begin : g_ram
      logic [9:0] px [L];
      logic [9:0] py [L];
      logic       pe [L];
      always @(posedge clk) begin
        px[0] <= ax_a[g];
        py[0] <= ay_a[g];
        pe[0] <= rd_en_a[g];
        for (int i = 1; i < L; i++) begin
          px[i] <= px[i-1];
          py[i] <= py[i-1];
          pe[i] <= pe[i-1];
        end
      end
      assign rdat = (pe[L-1] === 1'b1) ? pix(int'(px[L-1]), int'(py[L-1])) : junk;
    end
  end

  // Reference model: scan position plus a history of what entered stage 0
  // at each edge (most recent first). Output for latency L shows hq[L].
  typedef struct {
    bit ok;
    int h;
    int v;
  } ent_t;

  int   mh, mv;
  ent_t hq [5];
  int   cyc;
  int   fs_t [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_stage0();
    for (int g = 0; g < N; g++) begin
      int s;
      s = ss_of(g);
      chk($sformatf("rd_en[%0d]", g), rd_en_a[g], (en_i === 1'b1) && mh < 8 && mv < 4);
      chk($sformatf("addr_x[%0d]", g), ax_a[g], mh >> s);
      chk($sformatf("addr_y[%0d]", g), ay_a[g], mv >> s);
    end
  endtask

  task automatic check_out();
    for (int g = 0; g < N; g++) begin
      ent_t e;
      bit act, p;
      int s;
      e   = hq[lat_of(g)];
      s   = ss_of(g);
      p   = (pol_of(g) != 0);
      act = e.ok && e.h < 8 && e.v < 4;
      chk($sformatf("valid[%0d]", g), val_a[g], act);
      chk($sformatf("rgb[%0d]", g), rgb_a[g], act ? pix(e.h >> s, e.v >> s) : 24'd0);
      chk($sformatf("hsync[%0d]", g), hs_a[g], (e.ok && e.h >= 10 && e.h <= 11) ? p : !p);
      chk($sformatf("vsync[%0d]", g), vs_a[g], (e.ok && e.v == 5) ? p : !p);
      chk($sformatf("frame_start[%0d]", g), fs_a[g], act && e.h == 0 && e.v == 0);
      chk($sformatf("line_start[%0d]", g), ls_a[g], act && e.h == 0);
    end
  endtask

  task automatic model_edge();
    if (rst_i === 1'b1) begin
      mh = 0;
      mv = 0;
      for (int i = 0; i < 5; i++) hq[i] = '{ok: 1'b0, h: 0, v: 0};
    end else begin
      for (int i = 4; i > 0; i--) hq[i] = hq[i-1];
      hq[0] = '{ok: (en_i === 1'b1), h: mh, v: mv};
      if (en_i === 1'b1) begin
        mh++;
        if (mh == 14) begin
          mh = 0;
          mv++;
          if (mv == 7) mv = 0;
        end
      end
    end
  endtask

  // One pixel clock: drive inputs after the falling edge, check stage 0,
  // take the rising edge, then check the registered outputs on the next falling edge.
  task automatic tick(input logic r, input logic e);
    rst_i = r;
    en_i  = e;
    #1;
    check_stage0();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check_out();
    if (fs_a[0] === 1'b1) fs_t.push_back(cyc);
  endtask

  initial begin
    int n, last, n0;
    kr = 8'($urandom);
    kg = 8'($urandom);
    kb = 8'($urandom);
    rst_i = 1'b1;
    en_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mh = 0;
    mv = 0;
    for (int i = 0; i < 5; i++) hq[i] = '{ok: 1'b0, h: 0, v: 0};
    cyc = 0;

    // Reset state, including inactive sync levels for both polarities.
    repeat (2) tick(1'b1, 1'b0);

    // First pixel three cycles after release, then one full frame period.
    cyc = 0;
    fs_t.delete();
    repeat (3) tick(1'b0, 1'b1);
    chk("first_valid_at_3", val_a[0], 1'b1);
    chk("first_frame_start", fs_a[0], 1'b1);
    chk("first_rgb", rgb_a[0], pix(0, 0));
    n = 0;
    while (fs_t.size() < 2 && n < 300) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("frame_period_timeout", fs_t.size() >= 2, 1'b1);
    if (fs_t.size() >= 2) chk("frame_period", fs_t[1] - fs_t[0], 98);

    // Pause for 5 cycles at (3,1): the frame stretches by 5.
    n = 0;
    while (!(mh == 3 && mv == 1) && n < 200) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("reach_3_1_timeout", (mh == 3 && mv == 1), 1'b1);
    last = fs_t[fs_t.size()-1];
    n0   = fs_t.size();
    repeat (5) tick(1'b0, 1'b0);
    n = 0;
    while (fs_t.size() <= n0 && n < 200) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("paused_frame_timeout", fs_t.size() > n0, 1'b1);
    if (fs_t.size() > n0) chk("paused_frame_period", fs_t[n0] - last, 103);

    // Random enable pattern over several frames.
    repeat (400) tick(1'b0, ($urandom_range(0, 3) != 0));

    // One-cycle reset at (9,2): scan restarts at (0,0), first pixel 3 cycles later.
    n = 0;
    while (!(mh == 9 && mv == 2) && n < 200) begin
      tick(1'b0, 1'b1);
      n++;
    end
    chk("reach_9_2_timeout", (mh == 9 && mv == 2), 1'b1);
    tick(1'b1, 1'b1);
    chk("post_reset_addr_x", ax_a[0], 0);
    chk("post_reset_addr_y", ay_a[0], 0);
    repeat (2) tick(1'b0, 1'b1);
    chk("post_reset_blank", val_a[0], 1'b0);
    tick(1'b0, 1'b1);
    chk("post_reset_valid", val_a[0], 1'b1);

    // Two more clean frames for the doubled and latency-swept instances.
    repeat (200) tick(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
